// File: rtl/blc_pipe.sv
// Binary log converter: leading-one index plus normalised fraction.
// Two-stage valid/ready pipeline with a sideband tag.
module blc_pipe #(
  parameter int W  = 16,
  parameter int FW = W - 1,
  parameter int TW = 1,
  localparam int KW = $clog2(W),
  localparam int LW = KW + FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_log,
  output logic          out_zero,
  output logic [TW-1:0] out_tag
);

  localparam logic [KW-1:0] KMAX = KW'(W - 1);

  logic          s1_valid;
  logic [KW-1:0] s1_k;
  logic          s1_zero;
  logic [W-1:0]  s1_x;
  logic [TW-1:0] s1_tag;

  logic          s2_valid;
  logic [LW-1:0] s2_log;
  logic          s2_zero;
  logic [TW-1:0] s2_tag;

  logic          s1_load;
  logic          s2_load;
  logic [KW-1:0] lo_k;
  logic          in_zero;
  logic [W-2:0]  m;
  logic [FW-1:0] frac;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Leading-one index; highest set bit wins, zero input gives 0.
  always_comb begin
    lo_k = '0;
    for (int i = 0; i < W; i++) begin
      if (in_x[i]) lo_k = KW'(i);
    end
  end

  assign in_zero = (in_x == '0);

  // Normalise so the leading one falls off the top; keep bits below it.
  assign m = (W-1)'(s1_x << (KMAX - s1_k));

  generate
    if (FW == W - 1) begin : g_eq
      assign frac = m;
    end else if (FW > W - 1) begin : g_wide
      assign frac = {m, {(FW-W+1){1'b0}}};
    end else begin : g_narrow
      assign frac = m[W-2 -: FW];
    end
  endgenerate

  // S1: capture index, zero flag, operand and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_zero  <= 1'b0;
      s1_x     <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_k    <= lo_k;
        s1_zero <= in_zero;
        s1_x    <= in_x;
        s1_tag  <= in_tag;
      end
    end
  end

  // S2: capture formatted result; held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_log   <= '0;
      s2_zero  <= 1'b0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_log  <= {s1_k, frac};
        s2_zero <= s1_zero;
        s2_tag  <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_log   = s2_log;
  assign out_zero  = s2_zero;
  assign out_tag   = s2_tag;

endmodule

// File: tb/tb_blc_pipe.sv
// Directed bench for blc_pipe: conversions, streaming,
// backpressure, mid-flight reset and a W=8/FW=4 variant.
module tb_blc_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_log;
  logic        out_zero;
  logic [7:0]  out_tag;

  logic        v_in_valid;
  logic        v_in_ready;
  logic [7:0]  v_in_x;
  logic [0:0]  v_in_tag;
  logic        v_out_valid;
  logic        v_out_ready;
  logic [6:0]  v_out_log;
  logic        v_out_zero;
  logic [0:0]  v_out_tag;

  int checks = 0;
  int errors = 0;

  logic [15:0] xs [100];
  logic [7:0]  ts [100];

  blc_pipe #(.W(16), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_log(out_log), .out_zero(out_zero),
    .out_tag(out_tag)
  );

  blc_pipe #(.W(8), .FW(4), .TW(1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v_in_valid), .in_ready(v_in_ready),
    .in_x(v_in_x), .in_tag(v_in_tag),
    .out_valid(v_out_valid), .out_ready(v_out_ready),
    .out_log(v_out_log), .out_zero(v_out_zero),
    .out_tag(v_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] ref_log(input logic [15:0] x);
    int k;
    logic [15:0] s;
    k = 0;
    for (int i = 0; i < 16; i++) if (x[i]) k = i;
    s = x << (15 - k);
    return {k[3:0], s[14:0]};
  endfunction

  task automatic conv(input logic [15:0] x,
                      input logic [7:0]  t,
                      input logic [18:0] elog,
                      input logic        ezero);
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = t;
    tick;
    in_valid = 1'b0;
    in_x     = 16'hDEAD;
    chk("conv_lat1_valid", out_valid, 0);
    tick;
    chk("conv_valid", out_valid, 1);
    chk("conv_log", out_log, elog);
    chk("conv_zero", out_zero, ezero);
    chk("conv_tag", out_tag, t);
    tick;
    chk("conv_drain", out_valid, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_x        = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    v_in_valid  = 1'b0;
    v_in_x      = '0;
    v_in_tag    = '0;
    v_out_ready = 1'b1;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_log", out_log, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_tag", out_tag, 0);
    tick;
    tick;
    #2 rst_n = 1'b1;
    tick;

    conv(16'h8000, 8'h11, 19'h78000, 1'b0);
    conv(16'h00C0, 8'h22, 19'h3C000, 1'b0);
    conv(16'h0001, 8'h33, 19'h00000, 1'b0);
    conv(16'h0000, 8'h44, 19'h00000, 1'b1);

    for (int i = 0; i < 100; i++) begin
      xs[i] = 16'($urandom);
      ts[i] = 8'(i);
    end
    xs[7]  = 16'h0000;
    xs[20] = 16'hFFFF;
    for (int c = 0; c < 102; c++) begin
      if (c < 100) begin
        in_valid = 1'b1;
        in_x     = xs[c];
        in_tag   = ts[c];
      end else begin
        in_valid = 1'b0;
      end
      chk("strm_in_ready", in_ready, 1);
      tick;
      if (c == 0 || c == 101) begin
        chk("strm_idle", out_valid, 0);
      end else begin
        chk("strm_valid", out_valid, 1);
        chk("strm_log", out_log, ref_log(xs[c-1]));
        chk("strm_zero", out_zero, xs[c-1] == 16'h0);
        chk("strm_tag", out_tag, ts[c-1]);
      end
    end

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h0003;
    in_tag    = 8'hA1;
    chk("bp_rdy0", in_ready, 1);
    tick;
    chk("bp_rdy1", in_ready, 1);
    in_x   = 16'h0100;
    in_tag = 8'hA2;
    tick;
    chk("bp_rdy2_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_log", out_log, 19'h0C000);
    in_x   = 16'h4000;
    in_tag = 8'hA3;
    tick;
    chk("bp_hold_rdy", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_log", out_log, 19'h0C000);
    chk("bp_hold_tag", out_tag, 8'hA1);
    tick;
    chk("bp_hold2_log", out_log, 19'h0C000);
    chk("bp_hold2_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_comb_rdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_o2_valid", out_valid, 1);
    chk("bp_o2_log", out_log, 19'h40000);
    chk("bp_o2_tag", out_tag, 8'hA2);
    tick;
    chk("bp_o3_valid", out_valid, 1);
    chk("bp_o3_log", out_log, 19'h70000);
    chk("bp_o3_tag", out_tag, 8'hA3);
    tick;
    chk("bp_empty", out_valid, 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h1234;
    in_tag    = 8'hB1;
    tick;
    in_x   = 16'h0FFF;
    in_tag = 8'hB2;
    tick;
    in_valid = 1'b0;
    chk("mr_full_valid", out_valid, 1);
    chk("mr_full_rdy", in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_valid_now", out_valid, 0);
    chk("mr_rdy_now", in_ready, 1);
    chk("mr_log_now", out_log, 0);
    chk("mr_tag_now", out_tag, 0);
    tick;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("mr_no_stale", out_valid, 0);
    end
    conv(16'h0100, 8'hC1, 19'h40000, 1'b0);

    v_in_valid = 1'b1;
    v_in_x     = 8'h0B;
    tick;
    chk("v8_lat1", v_out_valid, 0);
    v_in_x = 8'hFF;
    tick;
    v_in_valid = 1'b0;
    chk("v8_0b_valid", v_out_valid, 1);
    chk("v8_0b_log", v_out_log, 7'h36);
    chk("v8_0b_zero", v_out_zero, 0);
    tick;
    chk("v8_ff_valid", v_out_valid, 1);
    chk("v8_ff_log", v_out_log, 7'h7F);
    tick;
    chk("v8_empty", v_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blc_pipe.md
BLC_PIPE -- requirements
Module: blc_pipe

Interface
REQ-001 Parameter W, default 16, operand width; legal values are 2 to 64.
REQ-002 Parameter FW, default W-1, fraction width of the log output; must be at least 1.
REQ-003 Parameter TW, default 1, width of the sideband tag carried alongside each operand.
REQ-004 Derived KW = $clog2(W) is the characteristic width, and LW = KW+FW is the log width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  in_x and in_tag are valid this cycle.
REQ-009 in_ready  out  1  block accepts the operand this cycle.
REQ-010 in_x  in  W  unsigned operand.
REQ-011 in_tag  in  TW  sideband tag, passed through unchanged.
REQ-012 out_valid  out  1  out_log, out_zero and out_tag are valid.
REQ-013 out_ready  in  1  downstream accepts the result this cycle.
REQ-014 out_log  out  LW  result {k, frac}, with k in the MSBs.
REQ-015 out_zero  out  1  the operand was zero.
REQ-016 out_tag  out  TW  tag of this result.

Function
REQ-017 k SHALL equal the index of the most-significant 1 in in_x; leading-one detection is internal, with no one-hot input.
REQ-018 Mantissa SHALL be defined as m = (in_x << (W-1-k))[W-2:0], i.e. the bits below the leading one, left-aligned.
REQ-019 frac SHALL be derived from m as follows:
- FW = W-1: frac = m.
- FW > W-1: frac = m followed by zero LSBs.
- FW < W-1: frac = m[W-2 -: FW], truncated with no rounding.
REQ-020 For in_x = 0, out_log SHALL be 0 and out_zero SHALL be 1; out_zero SHALL be 0 for every other input.
REQ-021 For in_x = 1, out_log SHALL be 0 and out_zero SHALL be 0.
REQ-022 The block SHALL be a 2-stage pipeline:
- S1 registers k, the zero flag, the operand and the tag.
- S2 registers the shifted, formatted result.
REQ-023 Each stage SHALL hold a valid bit.
REQ-024 With out_ready held at 1, latency from the in_valid&&in_ready edge to out_valid SHALL be exactly 2 cycles.
REQ-025 Throughput SHALL be 1 operand per cycle.
REQ-026 S2 SHALL load when !s2_valid || out_ready.
REQ-027 S1 SHALL load when !s1_valid || S2 loads.
REQ-028 in_ready SHALL equal !s1_valid || S2-load; it is combinational from out_ready, and there SHALL be no combinational path from in_valid.
REQ-029 A transfer SHALL occur only on valid&&ready at each port.
REQ-030 While out_valid && !out_ready, out_log, out_zero and out_tag SHALL hold stable.
REQ-031 out_valid SHALL NOT drop until a transfer occurs.
REQ-032 Operand order and tag association SHALL be preserved, with no loss or duplication.
REQ-033 With out_ready held at 0, the block SHALL accept at most 2 operands before deasserting in_ready.
REQ-034 When S2 drains and a new operand enters S1 in the same cycle, both moves SHALL complete in that cycle.
REQ-035 in_x and in_tag SHALL be don't-care when in_valid = 0; they SHALL NOT alter state.

Reset
REQ-036 While rst_n = 0, s1_valid, s2_valid and out_valid SHALL be 0.
REQ-037 While rst_n = 0, out_log, out_zero and out_tag SHALL be 0, and in_ready SHALL be 1.
REQ-038 Reset assertion SHALL take effect immediately, independent of clk.
REQ-039 Reset asserted mid-operation SHALL discard all in-flight operands, and none SHALL emerge after release.
REQ-040 The first operand accepted after reset release SHALL follow REQ-024 timing.

Verification
REQ-041 With defaults (W=16, FW=15) and out_ready=1, the bench SHALL check conversion values:
- x=0x8000 -> out_log=0x78000 (k=15, frac=0).
- x=0x00C0 -> out_log = {4'd7, 15'h4000} = 0x3C000, out_zero=0.
- x=0x0001 -> out_log=0, out_zero=0.
REQ-042 The bench SHALL check the zero case: x=0x0000 -> out_log=0 and out_zero=1, 2 cycles after acceptance.
REQ-043 The bench SHALL check back-to-back streaming:
- Stimulus: 100 random x values on consecutive cycles with out_ready=1.
- Response: results appear in order with matching tags, one per cycle, starting cycle 2.
REQ-044 The bench SHALL check backpressure:
- Stimulus: out_ready=0, then in_valid=1 with x = 0x0003, 0x0100, 0x4000.
- Response: in_ready drops after 2 acceptances.
- Response: out_log=0x0C000 is held stable.
- Stimulus: raise out_ready.
- Response: 0x0C000, 0x40000 and 0x70000 emerge in order.
REQ-045 The bench SHALL check reset mid-flight:
- Stimulus: assert rst_n=0 between clock edges with both stages valid.
- Response: out_valid goes 0 at once, and no stale result appears after release.
REQ-046 The bench SHALL check the parameter variant W=8, FW=4:
- x=0x0B -> k=3, frac=4'b0110, out_log=0x36.
- x=0xFF -> out_log=0x7F.
